hazard_ctrl: RTL and testbench

- Stall and flush controller that drives the hold and `null` (bubble) controls of the IF/ID and ID/EX pipeline registers and the PC hold.
- Decides which bubbles the pipeline registers insert:
  - detects load-use hazards against the instruction in EX;
  - tracks multiply/divide HI/LO latency with an internal countdown;
  - flushes wrong-path instructions on taken branches (resolved in EX) and jumps (resolved in ID).
- Sits beside the ID stage and reads decoded ID fields plus ID/EX register outputs.

---
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the IF/ID and ID/EX pipeline registers and the PC.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_hilo,
  input  logic             id_jump,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rt,
  input  logic             ex_md,
  input  logic             ex_branch_taken,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_null,
`ifdef HAZARD_PERF_EN
  output logic             id_ex_null,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`else
  output logic             id_ex_null,
  output logic             md_busy
`endif
);

  if (MD_LATENCY < 1 || MD_LATENCY > 15 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl: MD_LATENCY must be 1..15 and CNT_W at least 1");
  end

  localparam logic [3:0] MdReload = 4'(MD_LATENCY - 1);

  logic [3:0] md_cnt_q, md_cnt_d;
  logic       load_use, md_hazard, stall;

  // Every output is gated by reset so the pipeline sees no controls while reset is low.
  always_comb begin
    load_use  = ex_memrd && (ex_rt != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    md_busy   = reset && (ex_md || (md_cnt_q != 4'd0));
    md_hazard = id_hilo && md_busy;
    stall     = reset && (load_use || md_hazard);

    pc_hold    = 1'b0;
    if_id_hold = 1'b0;
    if_id_null = 1'b0;
    id_ex_null = 1'b0;
    if (reset) begin
      if (ex_branch_taken) begin
        if_id_null = 1'b1;
        id_ex_null = 1'b1;
      end else if (stall) begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        id_ex_null = 1'b1;
      end else if (id_jump) begin
        if_id_null = 1'b1;
      end
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (ex_md) begin
      md_cnt_d = MdReload;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall && !ex_branch_taken && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if ((ex_branch_taken || (id_jump && !stall)) && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LATENCY=4).
// Counter checks are compiled in only when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned CntW = 32;

  logic            clk;
  logic            reset;
  logic [4:0]      id_rs, id_rt, ex_rt;
  logic            id_use_rs, id_use_rt, id_hilo, id_jump;
  logic            ex_memrd, ex_md, ex_branch_taken;
  logic            pc_hold, if_id_hold, if_id_null, id_ex_null, md_busy;
`ifdef HAZARD_PERF_EN
  logic [CntW-1:0] stall_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {pc_hold, if_id_hold, if_id_null, id_ex_null, md_busy}
  logic [4:0] outs;
  assign outs = {pc_hold, if_id_hold, if_id_null, id_ex_null, md_busy};

  hazard_ctrl #(
    .MD_LATENCY(4),
    .CNT_W     (CntW)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_hilo        (id_hilo),
    .id_jump        (id_jump),
    .ex_memrd       (ex_memrd),
    .ex_rt          (ex_rt),
    .ex_md          (ex_md),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_null     (if_id_null),
`ifdef HAZARD_PERF_EN
    .id_ex_null     (id_ex_null),
    .md_busy        (md_busy),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`else
    .id_ex_null     (id_ex_null),
    .md_busy        (md_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp);
    #1;
    check_eq(tag, {27'd0, outs}, {27'd0, exp});
  endtask

  task automatic check_cnt(input string tag);
`ifdef HAZARD_PERF_EN
    check_eq({tag, "_stall_cnt"}, stall_cycles, exp_stall);
    check_eq({tag, "_flush_cnt"}, flush_count, exp_flush);
`endif
  endtask

  // si/sf: hand-derived counter increments expected at this edge
  task automatic step(input int si, input int sf);
    @(posedge clk);
    exp_stall += si;
    exp_flush += sf;
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_hilo = 1'b0; id_jump = 1'b0; ex_memrd = 1'b0; ex_rt = 5'd0;
    ex_md = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic set_load_use();
    ex_memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  initial begin
    // Reset forces every control low even with all hazards present
    reset = 1'b0;
    clear_inputs();
    set_load_use();
    ex_md = 1'b1; id_hilo = 1'b1; id_jump = 1'b1; ex_branch_taken = 1'b1;
    check_outs("rst_force", 5'b00000);
    step(0, 0);
    check_cnt("rst");
    clear_inputs();
    reset = 1'b1;
    check_outs("idle", 5'b00000);

    // Load-use on rs: one bubble, then the load leaves EX
    set_load_use();
    check_outs("lu_rs", 5'b11010);
    step(1, 0);
    check_cnt("lu_rs");
    ex_memrd = 1'b0;
    check_outs("lu_done", 5'b00000);

    // Load-use on rt, and the use-enable gate
    clear_inputs();
    ex_memrd = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    check_outs("lu_rt", 5'b11010);
    id_use_rt = 1'b0;
    check_outs("lu_use_gate", 5'b00000);

    // $0 never stalls
    clear_inputs();
    ex_memrd = 1'b1; ex_rt = 5'd0; id_use_rs = 1'b1; id_use_rt = 1'b1;
    check_outs("zero_reg", 5'b00000);

    // mult/div then mfhi: stall cycles t..t+3, release at t+4
    clear_inputs();
    ex_md = 1'b1; id_hilo = 1'b1;
    check_outs("md_t0", 5'b11011);
    step(1, 0);
    ex_md = 1'b0;
    check_outs("md_t1", 5'b11011);
    step(1, 0);
    check_outs("md_t2", 5'b11011);
    step(1, 0);
    check_outs("md_t3", 5'b11011);
    step(1, 0);
    check_outs("md_t4_release", 5'b00000);
    check_cnt("md");

    // md_busy without a HI/LO consumer does not stall
    clear_inputs();
    ex_md = 1'b1;
    check_outs("md_busy_only", 5'b00001);
    step(0, 0);
    ex_md = 1'b0;
    check_outs("md_busy_cnt3", 5'b00001);
    step(0, 0); step(0, 0); step(0, 0);
    check_outs("md_idle", 5'b00000);

    // Load-use and md_hazard together count as one stall cycle
    set_load_use();
    ex_md = 1'b1; id_hilo = 1'b1;
    check_outs("lu_md", 5'b11011);
    step(1, 0);
    check_cnt("lu_md");
    clear_inputs();
    step(0, 0); step(0, 0); step(0, 0);
    check_outs("lu_md_drain", 5'b00000);

    // Taken branch overrides a stall
    set_load_use();
    ex_branch_taken = 1'b1;
    check_outs("br_over_stall", 5'b00110);
    step(0, 1);
    check_cnt("br");

    // Jump: one IF/ID bubble
    clear_inputs();
    id_jump = 1'b1;
    check_outs("jump", 5'b00100);
    step(0, 1);
    id_jump = 1'b0;
    check_outs("jump_done", 5'b00000);
    check_cnt("jump");

    // Stall has priority over jump and the jump is not counted as a flush
    id_jump = 1'b1;
    set_load_use();
    check_outs("jump_stall", 5'b11010);
    step(1, 0);
    check_cnt("jump_stall");

    // Reset mid-countdown
    clear_inputs();
    ex_md = 1'b1;
    step(0, 0);
    ex_md = 1'b0;
    step(0, 0);
    check_outs("md_cnt2", 5'b00001);
    id_hilo = 1'b1;
    check_outs("md_cnt2_stall", 5'b11011);
    reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    check_outs("rst_mid", 5'b00000);
    check_cnt("rst_mid");
    step(0, 0);
    reset = 1'b1;
    check_outs("post_rst", 5'b00000);
    step(0, 0);
    check_outs("post_rst_edge", 5'b00000);
    check_cnt("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
